// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit-timing recovery for the USB RX path.
// Realigns a bit-phase counter on every D+/D- transition and raises a
// one-cycle en_sample strobe at SAMPLE_PHASE inside each bit time. Lock is
// dropped (with a one-cycle lock_lost pulse) once MAX_RUN+1 strobes pass
// without a transition.
// Optional feature macro: RX_BIT_TIMER_SYNC_EN adds a two-flop synchronizer
// on each line input ahead of the edge detector (+2 cycles edge latency).
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3,
    parameter int MAX_RUN      = 7,
    localparam int PHASE_W     = $clog2(CLKS_PER_BIT),
    localparam int RUN_W       = $clog2(MAX_RUN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_enable,
    input  logic               d_plus,
    input  logic               d_minus,
    output logic               en_sample,
    output logic               locked,
    output logic               lock_lost,
    output logic [PHASE_W-1:0] bit_phase
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_TRACK = 1'b1;

    localparam logic [PHASE_W-1:0] PH_LAST   = PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] PH_SAMPLE = PHASE_W'(SAMPLE_PHASE);
    localparam logic [RUN_W-1:0]   RUN_LAST  = RUN_W'(MAX_RUN);

    logic               w_dp;
    logic               w_dm;
    logic               r_last_dp;
    logic               r_last_dm;
    logic               w_edge;
    logic               w_strobe;

    logic [0:0]         r_state;
    logic [PHASE_W-1:0] r_phase;
    logic [RUN_W-1:0]   r_run;
    logic               r_lock_lost;

    logic [0:0]         w_state_nxt;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic [RUN_W-1:0]   w_run_nxt;
    logic               w_lost_nxt;

`ifdef RX_BIT_TIMER_SYNC_EN
    logic [1:0] r_dp_sync;
    logic [1:0] r_dm_sync;

    // Two-flop synchronizers, reset to the J line state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_sync <= 2'b11;
            r_dm_sync <= 2'b00;
        end else begin
            r_dp_sync <= {r_dp_sync[0], d_plus};
            r_dm_sync <= {r_dm_sync[0], d_minus};
        end
    end

    assign w_dp = r_dp_sync[1];
    assign w_dm = r_dm_sync[1];
`else
    assign w_dp = d_plus;
    assign w_dm = d_minus;
`endif

    // Previous line state for transition detection; runs in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_dp <= 1'b1;
            r_last_dm <= 1'b0;
        end else begin
            r_last_dp <= w_dp;
            r_last_dm <= w_dm;
        end
    end

    assign w_edge   = (w_dp != r_last_dp) | (w_dm != r_last_dm);

    // Moore strobe: a coincident edge does not suppress it
    assign w_strobe = (r_state == S_TRACK) && (r_phase == PH_SAMPLE);

    // Next-state, phase and run-length logic
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_run_nxt   = r_run;
        w_lost_nxt  = 1'b0;
        if (!rx_enable) begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = '0;
            w_run_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_phase_nxt = '0;
                    w_run_nxt   = '0;
                    if (w_edge) begin
                        w_state_nxt = S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (w_edge) begin
                        w_phase_nxt = '0;
                        w_run_nxt   = '0;
                    end else begin
                        w_phase_nxt = (r_phase == PH_LAST) ? '0 : r_phase + PHASE_W'(1);
                        if (w_strobe) begin
                            if (r_run == RUN_LAST) begin
                                w_state_nxt = S_IDLE;
                                w_phase_nxt = '0;
                                w_run_nxt   = '0;
                                w_lost_nxt  = 1'b1;
                            end else begin
                                w_run_nxt = r_run + RUN_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_phase_nxt = '0;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter and lock_lost pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_run       <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_run       <= w_run_nxt;
            r_lock_lost <= w_lost_nxt;
        end
    end

    assign en_sample = w_strobe;
    assign locked    = (r_state == S_TRACK);
    assign lock_lost = r_lock_lost;
    assign bit_phase = r_phase;

endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: directed checks of rx_bit_timer with default parameters.
// Cycle 0 is the first clock period after reset release; inputs change 1ns
// after the rising edge and outputs are sampled on the falling edge.
module tb_rx_bit_timer;

    localparam int CPB = 8;
    localparam int SPH = 3;
    localparam int MR  = 7;
`ifdef RX_BIT_TIMER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_enable;
    logic       d_plus;
    logic       d_minus;
    logic       en_sample;
    logic       locked;
    logic       lock_lost;
    logic [2:0] bit_phase;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic       o_s, o_lk, o_ll;
    logic [2:0] o_ph;

    typedef struct {
        logic       en;
        logic       dp;
        logic       dm;
        logic       s;
        logic       lk;
        logic       ll;
        logic [2:0] ph;
    } vec_t;

    typedef struct {
        int   c;
        logic v;
    } pt_t;

    vec_t vt[0:31];
    int   tog_q[$];
    int   exp_s[$];
    int   exp_ll[$];
    pt_t  lk_exp[$];
    int   en_lo;
    int   en_hi;
    logic lk_hist[0:127];

    always #5 clk = ~clk;

    rx_bit_timer #(
        .CLKS_PER_BIT(CPB),
        .SAMPLE_PHASE(SPH),
        .MAX_RUN     (MR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_enable(rx_enable),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .en_sample(en_sample),
        .locked   (locked),
        .lock_lost(lock_lost),
        .bit_phase(bit_phase)
    );

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        o_s  = en_sample;
        o_lk = locked;
        o_ll = lock_lost;
        o_ph = bit_phase;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rx_enable = 1'b1;
        d_plus    = 1'b1;
        d_minus   = 1'b0;
        @(negedge clk);
        chk("reset en_sample", -1, en_sample, 0);
        chk("reset locked", -1, locked, 0);
        chk("reset lock_lost", -1, lock_lost, 0);
        chk("reset bit_phase", -1, bit_phase, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_scn(input string nm, input int ncyc);
        int got_s[$];
        int got_ll[$];
        for (int c = 0; c < ncyc; c++) begin
            foreach (tog_q[k]) begin
                if (tog_q[k] == c) begin
                    d_plus  = ~d_plus;
                    d_minus = ~d_minus;
                end
            end
            rx_enable = !(c >= en_lo && c < en_hi);
            step();
            if (o_s !== 1'b0) got_s.push_back(c);
            if (o_ll !== 1'b0) got_ll.push_back(c);
            lk_hist[c] = o_lk;
        end
        chk({nm, " strobe count"}, ncyc, got_s.size(), exp_s.size());
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++)
            chk({nm, " strobe at"}, exp_s[i], got_s[i], exp_s[i]);
        chk({nm, " lock_lost count"}, ncyc, got_ll.size(), exp_ll.size());
        for (int i = 0; i < exp_ll.size() && i < got_ll.size(); i++)
            chk({nm, " lock_lost at"}, exp_ll[i], got_ll[i], exp_ll[i]);
        foreach (lk_exp[k])
            chk({nm, " locked"}, lk_exp[k].c, lk_hist[lk_exp[k].c], lk_exp[k].v);
        tog_q.delete();
        exp_s.delete();
        exp_ll.delete();
        lk_exp.delete();
        en_lo = -1;
        en_hi = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nv;
        int          ns;
        int          nlk;
        int          ph_tab[13];
        logic        s_tab[13];
        en_lo = -1;
        en_hi = -1;

        // Vector table: J idle, K at 10, J at 18 (pin timing)
        ph_tab = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4};
        s_tab  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        nv = 24 + LAT;
        for (int c = 0; c < nv; c++) begin
            vt[c].en = 1'b1;
            vt[c].dp = !(c >= 10 && c < 18);
            vt[c].dm = (c >= 10 && c < 18);
            vt[c].s  = 1'b0;
            vt[c].lk = 1'b0;
            vt[c].ll = 1'b0;
            vt[c].ph = 3'd0;
        end
        for (int k = 0; k < 13; k++) begin
            vt[11 + LAT + k].lk = 1'b1;
            vt[11 + LAT + k].ph = 3'(ph_tab[k]);
            vt[11 + LAT + k].s  = s_tab[k];
        end

        do_reset();
        for (int i = 0; i < nv; i++) begin
            rx_enable = vt[i].en;
            d_plus    = vt[i].dp;
            d_minus   = vt[i].dm;
            step();
            chk("vec en_sample", i, o_s, vt[i].s);
            chk("vec locked", i, o_lk, vt[i].lk);
            chk("vec lock_lost", i, o_ll, vt[i].ll);
            chk("vec bit_phase", i, o_ph, vt[i].ph);
        end

        // Idle lines for 100 cycles: never locks, never strobes
        do_reset();
        ns  = 0;
        nlk = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (o_s !== 1'b0) ns++;
            if (o_lk !== 1'b0) nlk++;
        end
        chk("idle strobes", 100, ns, 0);
        chk("idle locked cycles", 100, nlk, 0);
        chk("idle bit_phase", 100, o_ph, 0);

        // Steady stream, edge every 8 cycles
        do_reset();
        tog_q = '{10, 18, 26, 34};
        exp_s = '{14 + LAT, 22 + LAT, 30 + LAT, 38 + LAT};
        lk_exp.push_back('{10 + LAT, 1'b0});
        lk_exp.push_back('{11 + LAT, 1'b1});
        run_scn("stream", 42);

        // Edge two cycles early
        do_reset();
        tog_q = '{10, 16};
        exp_s = '{14 + LAT, 20 + LAT, 28 + LAT};
        run_scn("early", 32);

        // Edge coinciding with a strobe: strobe kept, phase realigned
        do_reset();
        tog_q = '{10, 14};
        exp_s = '{14 + LAT, 18 + LAT, 26 + LAT};
        run_scn("coincide", 30);

        // Single transition then silence: timeout after 8 strobes
        do_reset();
        tog_q  = '{10};
        exp_s  = '{14 + LAT, 22 + LAT, 30 + LAT, 38 + LAT, 46 + LAT, 54 + LAT, 62 + LAT, 70 + LAT};
        exp_ll = '{71 + LAT};
        lk_exp.push_back('{70 + LAT, 1'b1});
        lk_exp.push_back('{71 + LAT, 1'b0});
        lk_exp.push_back('{79, 1'b0});
        run_scn("timeout", 80);

        // rx_enable dropped mid-track, then relock
        do_reset();
        tog_q = '{10, 18, 40};
        en_lo = 25;
        en_hi = 30;
        exp_s = '{14 + LAT, 22 + LAT, 44 + LAT};
        lk_exp.push_back('{25, 1'b1});
        lk_exp.push_back('{26, 1'b0});
        lk_exp.push_back('{40 + LAT, 1'b0});
        lk_exp.push_back('{41 + LAT, 1'b1});
        run_scn("enable", 50);

        // Asynchronous reset in the strobe cycle
        do_reset();
        for (int c = 0; c < 14 + LAT; c++) begin
            if (c == 10) begin
                d_plus  = 1'b0;
                d_minus = 1'b1;
            end
            step();
        end
        chk("pre-reset bit_phase", cyc, bit_phase, 3);
        rst = 1'b1;
        #1;
        chk("midreset en_sample", cyc, en_sample, 0);
        chk("midreset locked", cyc, locked, 0);
        chk("midreset bit_phase", cyc, bit_phase, 0);
        chk("midreset lock_lost", cyc, lock_lost, 0);
        @(negedge clk);
        chk("midreset en_sample negedge", cyc, en_sample, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_bit_timer.md
# rx_bit_timer

Parametrised bit-timing recovery for the USB RX path. Watches the raw d_plus/d_minus pair, realigns an internal bit-phase counter on every line transition, and emits a one-cycle en_sample strobe at a programmable point inside each bit time. It also detects loss of lock when no transition arrives within a configurable number of bit times. It sits between the line inputs and the RX decoder/shifter, and generalises the fixed 8-clock, fixed-phase sample timer with variable oversampling, sample phase, enable gating and lock tracking.

## Interface
- CLKS_PER_BIT, default 8: clocks per USB bit; legal range ≥ 4.
- SAMPLE_PHASE, default 3: phase value at which en_sample fires; must be < CLKS_PER_BIT.
- MAX_RUN, default 7: bit times allowed without a transition before lock is dropped; ≥ 1.
- Derived widths:
  - PHASE_W = $clog2(CLKS_PER_BIT)
  - RUN_W = $clog2(MAX_RUN+1)
- One clock; reset is asynchronous and active-high.
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- rx_enable  input  1  synchronous enable; low forces IDLE.
- d_plus  input  1  USB D+ line.
- d_minus  input  1  USB D- line.
- en_sample  output  1  one-cycle sample strobe.
- locked  output  1  high while in TRACK.
- lock_lost  output  1  registered one-cycle pulse when a run timeout drops lock.
- bit_phase  output  PHASE_W  current phase counter value.

## Operation
- Edge detector:
  - Registers last_dp and last_dm reset to 1 and 0 (J state).
  - edge = (d_plus != last_dp) | (d_minus != last_dm), evaluated every cycle regardless of state.
- States: IDLE and TRACK.
- IDLE:
  - phase = 0, run = 0, en_sample = 0.
  - On edge & rx_enable → TRACK, with phase = 0 and run = 0 in the next cycle.
- TRACK, each cycle:
  - edge: phase ← 0, run ← 0.
  - No edge: phase ← (phase == CLKS_PER_BIT-1) ? 0 : phase+1.
  - en_sample = (state == TRACK) & (phase == SAMPLE_PHASE). This is a Moore output: an edge in the same cycle does not suppress the strobe.
  - On en_sample with no edge: if run == MAX_RUN → next state IDLE and lock_lost = 1 in the next cycle; otherwise run ← run+1.
  - If edge and en_sample coincide: the strobe is issued, run ← 0, and no timeout occurs.
- rx_enable low in any state: next state IDLE, counters cleared, no lock_lost pulse. Edge registers keep updating.
- Reset values:
  - en_sample = 0, locked = 0, lock_lost = 0, bit_phase = 0.
  - State is IDLE.
- Reset asserted mid-bit: all registers return to their reset values immediately; no strobe is issued.

## Timing
- First edge detected in cycle t from IDLE:
  - locked is high from cycle t+1.
  - The first en_sample is in cycle t+1+SAMPLE_PHASE.
  - Subsequent strobes follow every CLKS_PER_BIT cycles.
- Resync edge in cycle t while in TRACK: the next en_sample is in cycle t+1+SAMPLE_PHASE. An early or late edge therefore shortens or stretches the current bit; there are never two strobes within one bit.
- Timeout:
  - lock_lost pulses in the cycle after the (MAX_RUN+1)th strobe without an edge.
  - locked falls in that same cycle.
- bit_phase is registered; the edge detector adds no latency beyond the one-cycle phase reload.

## Configuration
- RX_BIT_TIMER_SYNC_EN:
  - Defined: d_plus and d_minus each pass through a two-flop synchronizer (reset values 1 and 0) before the edge detector. Every edge-related timing above shifts by +2 cycles.
  - Undefined: the inputs feed the edge detector directly; the inputs are assumed synchronous to clk.

## Test plan
All scenarios use the defaults (CLKS_PER_BIT = 8, SAMPLE_PHASE = 3, MAX_RUN = 7) and the macro undefined unless stated.
- Reset, rx_enable = 1, lines idle at J → locked = 0, en_sample never asserts over 100 cycles, bit_phase = 0.
- Toggle to K at cycle 10, then alternate every 8 cycles → locked from 11; en_sample at cycles 14, 22, 30, …; lock_lost stays 0.
- Edge 2 cycles early (cycle 16 instead of 18) in a steady stream → strobe at cycle 20, next at 28; no double strobe.
- Single transition at cycle 10, then lines held → 8 strobes (cycles 14 … 70); lock_lost pulses at 71; locked = 0 from 71.
- Drop rx_enable mid-TRACK at cycle 25 → locked = 0 at 26, no lock_lost pulse. Re-assert, then edge at 40 → strobe at 44.
- Macro defined, edge on the pins at cycle 10 → locked at 13, first en_sample at 16.
